// File: rtl/instr_encoder.sv
// Sequential MIPS instruction encoder: packs class/field requests into 32-bit words
// and streams them to consecutive imem word addresses starting at BASE.
module instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [2:0]        in_func,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err_illegal,
  output logic [1:0]        state_dbg
);

  // Handshake: a request is taken on a rising edge where in_valid && in_ready;
  // in_ready depends on registered state only, never on in_valid.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FULL = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE);

  state_t            state, state_nx;
  logic              accept;
  logic              legal;
  logic              wr_go;
  logic [31:0]       enc;
  logic [5:0]        funct;
  logic [ADDR_W:0]   count_nx;
  logic              err_nx;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: start beats stop, stop beats filling up
  always_comb begin
    state_nx = state;
    if (start)                                   state_nx = S_RUN;
    else if (stop)                               state_nx = S_IDLE;
    else if (state == S_RUN && count_nx == DEPTH_C) state_nx = S_FULL;
  end

  // Outputs decoded from registered state
  always_comb begin
    in_ready  = (state == S_RUN) && (count < DEPTH_C);
    full      = (state == S_FULL);
    state_dbg = state;
  end

  always_comb begin
    legal = 1'b1;
    if (in_class > 3'd4)                         legal = 1'b0;
    else if (in_class == 3'd0 && in_func > 3'd4) legal = 1'b0;
  end

  assign accept = in_valid && in_ready;
  assign wr_go  = accept && legal;

  always_comb begin
    funct = 6'b100000;
    case (in_func)
      3'd1:    funct = 6'b100010;
      3'd2:    funct = 6'b100100;
      3'd3:    funct = 6'b100101;
      3'd4:    funct = 6'b101010;
      default: funct = 6'b100000;
    endcase
  end

  always_comb begin
    enc = 32'd0;
    case (in_class)
      3'd0:    enc = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, funct};
      3'd1:    enc = {6'b100011, in_rs, in_rt, in_imm};
      3'd2:    enc = {6'b101011, in_rs, in_rt, in_imm};
      3'd3:    enc = {6'b000100, in_rs, in_rt, in_imm};
      3'd4:    enc = {6'b000010, in_target};
      default: enc = 32'd0;
    endcase
  end

  always_comb begin
    count_nx = count;
    err_nx   = err_illegal;
    if (start) begin
      count_nx = '0;
      err_nx   = 1'b0;
    end else begin
      if (wr_go)            count_nx = count + 1'b1;
      if (accept && !legal) err_nx   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      err_illegal <= 1'b0;
    end else begin
      count       <= count_nx;
      err_illegal <= err_nx;
    end
  end

  // Write pipeline drains independently of state so a word taken alongside stop/start still lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= wr_go;
      if (wr_go) begin
        imem_addr  <= BASE_C + count[ADDR_W-1:0];
        imem_wdata <= enc;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder (DEPTH=4): vector table, corner sequences and random stream
// against a field-arithmetic reference model with an expected-write queue.
module tb_instr_encoder;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;
  localparam int BASE   = 0;

  logic              clk, rst_n, start, stop, in_valid, in_ready;
  logic [2:0]        in_class, in_func;
  logic [4:0]        in_rs, in_rt, in_rd;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              imem_we, full, err_illegal;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic [1:0]        state_dbg;

  instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class), .in_func(in_func),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .full(full), .err_illegal(err_illegal), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int          m_mode;  // 0 idle, 1 run, 2 full
  int          m_cnt;
  bit          m_err;
  bit          m_we;
  logic [7:0]  m_addr;
  logic [31:0] m_data;
  logic [ADDR_W+31:0] exp_q[$];

  int opc[5]       = '{0, 35, 43, 4, 2};
  int funct_tab[5] = '{32, 34, 36, 37, 42};

  typedef struct {
    logic [2:0]  cls;
    logic [2:0]  fn;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[12];

  function automatic logic [31:0] ref_word(int cls, int fn, int rs, int rt, int rd,
                                           int imm, int tgt);
    longint w;
    w = longint'(opc[cls]) * 64'd67108864;
    if (cls == 4) w = w + tgt;
    else begin
      w = w + longint'(rs) * 2097152 + longint'(rt) * 65536;
      if (cls == 0) w = w + longint'(rd) * 2048 + funct_tab[fn];
      else          w = w + imm;
    end
    return w[31:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_err = 0; m_we = 0;
    m_addr = '0; m_data = '0;
    exp_q.delete();
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_we"},    imem_we, m_we);
    chk({tag, "_addr"},  imem_addr, m_addr);
    chk({tag, "_wdata"}, imem_wdata, m_data);
    chk({tag, "_count"}, count, m_cnt);
    chk({tag, "_full"},  full, m_mode == 2);
    chk({tag, "_err"},   err_illegal, m_err);
    chk({tag, "_ready"}, in_ready, (m_mode == 1) && (m_cnt < DEPTH));
  endtask

  // driver: apply one cycle of inputs, advance the model, check after the edge
  task automatic step(input string tag, input bit st, input bit sp, input bit v,
                      input logic [2:0] cls, input logic [2:0] fn,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [15:0] imm, input logic [25:0] tgt);
    bit rdy, acc, lg;
    start = st; stop = sp; in_valid = v; in_class = cls; in_func = fn;
    in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_target = tgt;
    rdy = (m_mode == 1) && (m_cnt < DEPTH);
    acc = v && rdy;
    lg  = (cls < 5) && !(cls == 0 && fn > 4);
    m_we = acc && lg;
    if (m_we)
      exp_q.push_back({8'(BASE + m_cnt),
                       ref_word(int'(cls), int'(fn), int'(rs), int'(rt), int'(rd),
                                int'(imm), int'(tgt))});
    if (st) begin
      m_mode = 1; m_cnt = 0; m_err = 0;
    end else begin
      if (acc && lg)  m_cnt++;
      if (acc && !lg) m_err = 1;
      if (sp) m_mode = 0;
      else if (m_mode == 1 && m_cnt == DEPTH) m_mode = 2;
    end
    @(posedge clk);
    #1;
    if (m_we && exp_q.size() > 0) {m_addr, m_data} = exp_q.pop_front();
    check_outputs(tag);
  endtask

  task automatic do_start();
    step("start", 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
  endtask

  task automatic add_req(input string tag, input bit st, input bit sp, input logic [4:0] rd);
    step(tag, st, sp, 1'b1, 3'd0, 3'd0, 5'd1, 5'd2, rd, 16'd0, 26'd0);
  endtask

  initial begin
    tbl[0]  = '{3'd1, 3'd0, 5'd0,  5'd8,  5'd0,  16'h0004, 26'd0,        32'h8C080004};
    tbl[1]  = '{3'd2, 3'd0, 5'd0,  5'd8,  5'd0,  16'h0008, 26'd0,        32'hAC080008};
    tbl[2]  = '{3'd3, 3'd0, 5'd1,  5'd2,  5'd0,  16'hFFFF, 26'd0,        32'h1022FFFF};
    tbl[3]  = '{3'd4, 3'd0, 5'd0,  5'd0,  5'd0,  16'h0000, 26'h0000010,  32'h08000010};
    tbl[4]  = '{3'd0, 3'd0, 5'd1,  5'd2,  5'd3,  16'h0000, 26'd0,        32'h00221820};
    tbl[5]  = '{3'd0, 3'd1, 5'd1,  5'd2,  5'd3,  16'h0000, 26'd0,        32'h00221822};
    tbl[6]  = '{3'd0, 3'd2, 5'd1,  5'd2,  5'd3,  16'h0000, 26'd0,        32'h00221824};
    tbl[7]  = '{3'd0, 3'd3, 5'd1,  5'd2,  5'd3,  16'h0000, 26'd0,        32'h00221825};
    tbl[8]  = '{3'd0, 3'd4, 5'd4,  5'd5,  5'd6,  16'h0000, 26'd0,        32'h0085302A};
    tbl[9]  = '{3'd4, 3'd5, 5'd9,  5'd9,  5'd9,  16'h1234, 26'h3FFFFFF,  32'h0BFFFFFF};
    tbl[10] = '{3'd1, 3'd7, 5'd31, 5'd31, 5'd5,  16'h8000, 26'h1555555,  32'h8FFF8000};
    tbl[11] = '{3'd0, 3'd0, 5'd0,  5'd0,  5'd31, 16'hFFFF, 26'h2AAAAAA,  32'h0000F820};

    rst_n = 1'b0; start = 0; stop = 0; in_valid = 0; in_class = 0; in_func = 0;
    in_rs = 0; in_rt = 0; in_rd = 0; in_imm = 0; in_target = 0;
    model_reset();
    #12;
    check_outputs("reset");
    rst_n = 1'b1;

    // vector table: LW/SW/BEQ/J back-to-back at 0..3, then RTYPE variants
    for (int i = 0; i < 12; i++) begin
      if (i % 4 == 0) do_start();
      step("tbl", 1'b0, 1'b0, 1'b1, tbl[i].cls, tbl[i].fn, tbl[i].rs, tbl[i].rt,
           tbl[i].rd, tbl[i].imm, tbl[i].tgt);
      chk("tbl_we", imem_we, 1'b1);
      chk("tbl_word", imem_wdata, tbl[i].exp);
      chk("tbl_addr", imem_addr, 8'(i % 4));
    end

    // illegal class, then illegal funct; error sticks through a legal write
    do_start();
    step("ill_cls", 1'b0, 1'b0, 1'b1, 3'd6, 3'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
    step("ill_fn", 1'b0, 1'b0, 1'b1, 3'd0, 3'd7, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
    chk("ill_no_count", count, 0);
    add_req("ill_then_ok", 1'b0, 1'b0, 5'd3);
    chk("ill_sticky", err_illegal, 1'b1);
    do_start();
    chk("ill_cleared", err_illegal, 1'b0);

    // fill to DEPTH with five requests; fifth is refused
    do_start();
    for (int i = 0; i < 5; i++) add_req("fill", 1'b0, 1'b0, 5'(i));
    chk("fill_full", full, 1'b1);
    chk("fill_ready", in_ready, 1'b0);
    chk("fill_count", count, DEPTH);
    step("fill_idle", 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);

    // acceptance together with stop still writes; IDLE ignores requests
    do_start();
    add_req("stop_acc", 1'b0, 1'b1, 5'd7);
    chk("stop_wrote", imem_we, 1'b1);
    add_req("idle_req", 1'b0, 1'b0, 5'd8);
    chk("idle_no_we", imem_we, 1'b0);
    step("st_sp", 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    chk("st_sp_ready", in_ready, 1'b1);

    // start while a write is pending: old address still issues, next word to BASE
    add_req("pend_a", 1'b0, 1'b0, 5'd1);
    add_req("pend_b", 1'b0, 1'b0, 5'd2);
    step("pend_start", 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    chk("pend_addr", imem_addr, 8'(BASE + 1));
    add_req("pend_next", 1'b0, 1'b0, 5'd3);
    chk("pend_base", imem_addr, 8'(BASE));

    // asynchronous reset right after an acceptance
    add_req("rst_acc", 1'b0, 1'b0, 5'd9);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // randomized stream
    for (int i = 0; i < 400; i++) begin
      bit st, sp, v;
      logic [2:0] cls, fn;
      st  = ($urandom_range(0, 14) == 0);
      sp  = ($urandom_range(0, 19) == 0);
      v   = ($urandom_range(0, 9) < 7);
      cls = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      fn  = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      step("rand", st, sp, v, cls, fn, 5'($urandom), 5'($urandom), 5'($urandom),
           16'($urandom), 26'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Sequential instruction encoder. It is the inverse of the main control decoder: it packs instruction-class requests and register/immediate fields into 32-bit MIPS words and streams them into instruction memory at consecutive word addresses. It sits between a bench or boot loader front-end and the imem write port. It covers exactly the classes the control decoder recognises: R-type, lw, sw, beq, j.

Parameters:
ADDR_W, 8, imem word-address width
DEPTH, 256, number of words the block may write per program (must be ≤ 2^ADDR_W and ≥ 1)
BASE, 0, word address of the first instruction written after start

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous, active-low reset
start  in  1  pulse: clear count and error, enter RUN
stop  in  1  pulse: leave RUN/FULL and return to IDLE
in_valid  in  1  request valid
in_ready  out  1  block can accept a request this cycle
in_class  in  3  0=RTYPE, 1=LW, 2=SW, 3=BEQ, 4=J; 5–7 illegal
in_func  in  3  RTYPE only: 0=add, 1=sub, 2=and, 3=or, 4=slt; 5–7 illegal
in_rs  in  5  rs field
in_rt  in  5  rt field
in_rd  in  5  rd field (RTYPE only)
in_imm  in  16  immediate (LW/SW/BEQ)
in_target  in  26  jump target (J)
imem_we  out  1  one-cycle write strobe
imem_addr  out  ADDR_W  word address
imem_wdata  out  32  encoded instruction
count  out  ADDR_W+1  words accepted since start
full  out  1  high in FULL state
err_illegal  out  1  sticky: an illegal class/func was presented

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0: imem_we, imem_addr, imem_wdata, count, full, err_illegal, in_ready.
- States: IDLE, RUN, FULL.
  - IDLE→RUN on start.
  - RUN→FULL when count reaches DEPTH.
  - RUN/FULL→IDLE on stop.
  - start in any state restarts RUN: count=0, err_illegal=0.
  - start and stop in the same cycle: start wins.
- in_ready = (state==RUN) && (count < DEPTH). It is a function of registered state only; there is no combinational path from in_valid.
- Acceptance: in_valid && in_ready at edge N.
  - Legal request: at cycle N+1, imem_we=1, imem_addr=BASE+count_old, imem_wdata=encoded word; count increments at edge N.
  - Throughput: one word per cycle, latency 1.
  - Illegal class or func: no write, count unchanged, err_illegal set and held until start or reset.
- imem_we is high only in the cycle after a legal acceptance. imem_addr and imem_wdata hold their last values otherwise.
- A word accepted in the cycle of stop, or in the cycle before it, still completes its write. The pipeline register drains regardless of state.
- Encoding, bit order {31:26, 25:21, 20:16, 15:11, 10:6, 5:0}:
  - RTYPE: {000000, rs, rt, rd, 00000, funct}. funct: add=100000, sub=100010, and=100100, or=100101, slt=101010.
  - LW: {100011, rs, rt, imm}.
  - SW: {101011, rs, rt, imm}.
  - BEQ: {000100, rs, rt, imm}.
  - J: {000010, target}.
  - Unused input fields are ignored.
- Address arithmetic: BASE+count is truncated to ADDR_W. Wrap-around is permitted only when BASE+DEPTH > 2^ADDR_W, which is a configuration error and is not checked.
- Reset mid-operation: any pending write is cancelled immediately; imem_we goes to 0 asynchronously.
- start while a write is pending: the pending write still issues with its old address. The next accepted word goes to BASE.

Test Plan:
- Reset, start; present RTYPE add rs=1 rt=2 rd=3 → next cycle imem_we=1, addr=0, wdata=0x00221820; count=1.
- Back-to-back in_valid: LW rs=0 rt=8 imm=0x0004, then SW rs=0 rt=8 imm=0x0008, then BEQ rs=1 rt=2 imm=0xFFFF, then J target=0x0000010 → wdata 0x8C080004, 0xAC080008, 0x1022FFFF, 0x08000010 at addrs 0–3 on consecutive cycles.
- in_class=6, then RTYPE func=7 → no imem_we, count unchanged, err_illegal=1 until next start.
- DEPTH=4: stream 5 valid requests → 4 writes at addrs 0–3, full=1, in_ready=0; 5th request is not accepted.
- Request accepted in the same cycle as stop → its write still occurs; the next request is ignored in IDLE. Then start+stop together → RUN, count=0.
- Assert rst_n=0 in the cycle after an acceptance → imem_we drops immediately, all outputs 0, state IDLE.
